// File: rtl/seg_digit_scan.sv
// Four-digit multiplexed 7-segment scanner: blank gap between digits, optional
// leading-zero suppression and frame-aligned display word updates.
module seg_digit_scan #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_GAP   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_i,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  anode,
  output logic [3:0]  digit,
  output logic        frame_start
);

  localparam int unsigned TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [TW-1:0] TLAST = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] GAPT  = TW'(BLANK_GAP);

  typedef enum logic {PH_GAP, PH_ON} phase_t;

  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   pend_val_q, pend_val_d;
  logic          pend_q, pend_d;
  logic [3:0]    anode_q, anode_d;
  logic [3:0]    digit_q, digit_d;
  logic          fs_q, fs_d;
  logic          slot_end, boundary, lead_zero;
  logic [3:0]    nib;
  phase_t        phase_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q    <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      anode_q    <= '1;
      digit_q    <= '1;
      fs_q       <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      anode_q    <= anode_d;
      digit_q    <= digit_d;
      fs_q       <= fs_d;
    end
  end

  always_comb begin
    slot_end   = (timer_q == TLAST);
    boundary   = slot_end && (idx_q == 2'd3);
    timer_d    = slot_end ? '0 : timer_q + TW'(1);
    idx_d      = slot_end ? idx_q + 2'd1 : idx_q;
    shadow_d   = shadow_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    if (boundary) begin
      // A load coinciding with the boundary supersedes any pending word.
      if (load) begin
        shadow_d = value_i;
        pend_d   = 1'b0;
      end else if (pend_q) begin
        shadow_d = pend_val_q;
        pend_d   = 1'b0;
      end
    end else if (load) begin
      pend_val_d = value_i;
      pend_d     = 1'b1;
    end
  end

  // Outputs are decoded from next-state so the registered anode/digit line up
  // with the timer/idx value they describe.
  always_comb begin
    phase_d = (timer_d < GAPT) ? PH_GAP : PH_ON;
    unique case (idx_d)
      2'd3:    lead_zero = (shadow_d[15:12] == 4'h0);
      2'd2:    lead_zero = (shadow_d[15:8]  == 8'h00);
      2'd1:    lead_zero = (shadow_d[15:4]  == 12'h000);
      default: lead_zero = 1'b0;
    endcase
    nib     = shadow_d[{idx_d, 2'b00} +: 4];
    anode_d = '1;
    digit_d = '1;
    if (phase_d == PH_ON) begin
      anode_d = ~(4'b0001 << idx_d);
      digit_d = (blank_lz && lead_zero) ? 4'hF : nib;
    end
    fs_d = boundary;
  end

  assign anode       = anode_q;
  assign digit       = digit_q;
  assign frame_start = fs_q;

endmodule
